traffic_gen_mc_engine: RTL

//  Native-RTL multi-channel successor of the single-stream traffic generator kernel.
//  NCH independent channels each issue n_total_reqs write-request beats in bursts:
//  t_ck_reqs-cycle request windows separated by t_ck_idle-cycle gaps. Each channel

---
 rtl/traffic_gen_mc_engine.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/traffic_gen_mc_engine.sv
// ---------------------------------------------------------------------------
// traffic_gen_mc_engine
//
// Multi-channel traffic generator. Each of NCH channels issues n_total write
// request beats in bursts: request windows of t_ck_reqs cycles separated by
// gaps of t_ck_idle cycles. Each channel also consumes the matching response
// stream. Control follows the ap_start/ap_done/ap_idle/ap_ready model.
//
// Top FSM:  IDLE -start-> RUN -all issued-> DRAIN -all received-> DONE -> IDLE
// Window sub-FSM (RUN only, shared by all channels): WIN <-> GAP
// The top state register state_q and the window phase register phase_q are
// the observation points for bound checkers.
//
// Optional feature macro: TRAFFIC_GEN_MC_CHECK_EN
//   defined     : every accepted response is compared with the expected
//                 payload; err_cnt_o counts mismatches (saturating) and
//                 clears on an accepted start.
//   not defined : no compare logic; err_cnt_o is tied to 0.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   test_mode_i       test mode, no functional effect
//   start_i           start pulse, honoured only in IDLE
//   n_total_reqs_i    beats per channel            (latched on start)
//   t_ck_reqs_i       window length, 0 acts as 1   (latched on start)
//   t_ck_idle_i       gap length, 0 = no gap       (latched on start)
//   w_valid_o/w_ready_i/w_data_o   per-channel request stream, ch c at [c*DW +: DW]
//   r_valid_i/r_ready_o/r_data_i   per-channel response stream
//   done_o, ready_o   one-cycle pulse in DONE
//   idle_o            high in IDLE
//   err_cnt_o         response mismatch count
//
// Handshake: a beat transfers on a cycle where valid and ready are both high.
// Once valid is raised it stays high, with data unchanged, until that cycle.
// ---------------------------------------------------------------------------
module traffic_gen_mc_engine #(
    parameter int NCH = 4,
    parameter int DW  = 64,
    parameter int CW  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              test_mode_i,
    input  logic              start_i,
    input  logic [CW-1:0]     n_total_reqs_i,
    input  logic [CW-1:0]     t_ck_reqs_i,
    input  logic [CW-1:0]     t_ck_idle_i,
    output logic [NCH-1:0]    w_valid_o,
    input  logic [NCH-1:0]    w_ready_i,
    output logic [NCH*DW-1:0] w_data_o,
    input  logic [NCH-1:0]    r_valid_i,
    output logic [NCH-1:0]    r_ready_o,
    input  logic [NCH*DW-1:0] r_data_i,
    output logic              done_o,
    output logic              idle_o,
    output logic              ready_o,
    output logic [CW-1:0]     err_cnt_o
);

    if (DW < 40) begin : g_dw_check
        $error("traffic_gen_mc_engine: DW must be at least 40");
    end
    if (NCH < 1 || NCH > 256) begin : g_nch_check
        $error("traffic_gen_mc_engine: NCH must be in 1..256");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } top_state_t;

    typedef enum logic {
        PH_WIN = 1'b0,
        PH_GAP = 1'b1
    } phase_t;

    top_state_t    state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] win_cnt_q, win_cnt_d;
    logic [CW-1:0] gap_cnt_q, gap_cnt_d;
    logic [CW-1:0] n_total_q, t_reqs_q, t_idle_q;
    logic [CW-1:0] t_reqs_eff;
    logic [CW-1:0] issued_q [NCH];
    logic [CW-1:0] rcvd_q   [NCH];

    logic           start_acc;
    logic           all_parked;
    logic           all_rcvd;
    logic           stall_any;
    logic           win_end;
    logic           gap_end;
    logic [NCH-1:0] w_fire;
    logic [NCH-1:0] r_fire;

    logic unused_inputs;
    assign unused_inputs = ^{test_mode_i, r_data_i};

    assign start_acc  = (state_q == ST_IDLE) && start_i;
    assign t_reqs_eff = (t_reqs_q == '0) ? CW'(1) : t_reqs_q;
    assign w_fire     = w_valid_o & w_ready_i;
    assign r_fire     = r_valid_i & r_ready_o;
    // A raised valid that has not been taken keeps the window open.
    assign stall_any  = |(w_valid_o & ~w_ready_i);
    assign win_end    = win_cnt_q >= (t_reqs_eff - CW'(1));
    assign gap_end    = gap_cnt_q >= (t_idle_q - CW'(1));

    // Per-channel stream outputs and completion flags
    always_comb begin
        w_valid_o  = '0;
        w_data_o   = '0;
        r_ready_o  = '0;
        all_parked = 1'b1;
        all_rcvd   = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (issued_q[c] < n_total_q) begin
                all_parked = 1'b0;
            end
            if (rcvd_q[c] != n_total_q) begin
                all_rcvd = 1'b0;
            end
            if (state_q == ST_RUN && phase_q == PH_WIN && issued_q[c] < n_total_q) begin
                w_valid_o[c]               = 1'b1;
                // Payload depends only on issued_q, so it holds across a stall.
                w_data_o[c*DW +: 32]       = 32'(issued_q[c]);
                w_data_o[c*DW + 32 +: 8]   = 8'(c);
            end
            r_ready_o[c] = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        end
    end

    // Top FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i)    state_d = ST_RUN;
            ST_RUN:   if (all_parked) state_d = ST_DRAIN;
            ST_DRAIN: if (all_rcvd)   state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Window / gap sequencing, common to all channels
    always_comb begin
        phase_d   = phase_q;
        win_cnt_d = win_cnt_q;
        gap_cnt_d = gap_cnt_q;
        if (start_acc) begin
            phase_d   = PH_WIN;
            win_cnt_d = '0;
            gap_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            if (phase_q == PH_WIN) begin
                if (win_end && !stall_any) begin
                    win_cnt_d = '0;
                    if (t_idle_q != '0) begin
                        phase_d   = PH_GAP;
                        gap_cnt_d = '0;
                    end
                end else if (!win_end) begin
                    win_cnt_d = win_cnt_q + CW'(1);
                end
            end else begin
                if (gap_end) begin
                    phase_d   = PH_WIN;
                    win_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            phase_q   <= PH_WIN;
            win_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            win_cnt_q <= win_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_total_q <= '0;
            t_reqs_q  <= '0;
            t_idle_q  <= '0;
        end else if (start_acc) begin
            n_total_q <= n_total_reqs_i;
            t_reqs_q  <= t_ck_reqs_i;
            t_idle_q  <= t_ck_idle_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NCH; c++) begin
                issued_q[c] <= '0;
                rcvd_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (start_acc) begin
                    issued_q[c] <= '0;
                    rcvd_q[c]   <= '0;
                end else begin
                    if (w_fire[c]) begin
                        issued_q[c] <= issued_q[c] + CW'(1);
                    end
                    // Beats beyond n_total are accepted but not counted.
                    if (r_fire[c] && rcvd_q[c] < n_total_q) begin
                        rcvd_q[c] <= rcvd_q[c] + CW'(1);
                    end
                end
            end
        end
    end

`ifdef TRAFFIC_GEN_MC_CHECK_EN
    logic [CW-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        for (int c = 0; c < NCH; c++) begin
            if (r_fire[c] &&
                ((r_data_i[c*DW +: 32] != 32'(rcvd_q[c])) ||
                 (r_data_i[c*DW + 32 +: 8] != 8'(c))) &&
                (err_cnt_d != '1)) begin
                err_cnt_d = err_cnt_d + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (start_acc) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

    assign idle_o  = (state_q == ST_IDLE);
    assign done_o  = (state_q == ST_DONE);
    assign ready_o = (state_q == ST_DONE);

endmodule
